// File: rtl/fb_pkg.sv
// fb_pkg: shared sizes and FSM encoding for the OV7670 frame-buffer capture controller.
package fb_pkg;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 8;
    localparam int FB_SIZE = 76800;
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_SIZE - 1);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLEAR   = 2'd1;
    localparam logic [1:0] ST_ARMED   = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;
endpackage

// File: rtl/fb_clear_engine.sv
// fb_clear_engine: sequential address generator for filling the frame buffer.
module fb_clear_engine
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic              clr,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              clr_last
);
    assign clr_we   = run & ~stall;
    assign clr_last = clr_we & (clr_addr == FB_LAST);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            clr_addr <= '0;
        else if (clr)
            clr_addr <= '0;
        else if (clr_we)
            clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    end
endmodule

// File: rtl/fb_capture_ctrl.sv
// fb_capture_ctrl: frame-aligned capture sequencer owning the frame-buffer write port,
// arbitrating the camera write stream against the internal clear engine.
module fb_capture_ctrl
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_cont,
    input  logic              clear_req,
    input  logic              abort,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              vsync,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_data,
    output logic              cap_start,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic              busy,
    output logic              clearing,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              err
);
    logic [1:0]        state;
    logic              vsync_q, seen, after_arm, mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we, clr_last;
    logic              rise, fall, cap_grant, cap_err, enter;
    assign rise      = vsync & ~vsync_q;
    assign fall      = ~vsync & vsync_q;
    assign busy      = state != ST_IDLE;
    assign clearing  = state == ST_CLEAR;
    // the capture stream cannot stall, so it always wins the port; the clear yields
    assign cap_grant = cap_we & (cap_addr <= FB_LAST) & (state == ST_CLEAR || state == ST_CAPTURE);
    assign cap_err   = cap_we & ~cap_grant;
    assign enter     = (state == ST_IDLE) & ~abort & (clear_req | start);
    fb_clear_engine u_clr (
        .clk      (clk),
        .rst      (rst),
        .run      (clearing & ~abort),
        .stall    (cap_grant),
        .clr      (abort),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .clr_last (clr_last)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            vsync_q    <= 1'b0;
            seen       <= 1'b0;
            after_arm  <= 1'b0;
            mode_q     <= 1'b0;
            fill_q     <= '0;
            cap_start  <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            cap_start  <= 1'b0;
            frame_done <= 1'b0;
            fb_we      <= cap_grant | clr_we;
            err        <= cap_err | (err & ~enter);
            if (cap_grant) begin
                fb_addr <= cap_addr;
                fb_data <= cap_data;
            end else if (clr_we) begin
                fb_addr <= clr_addr;
                fb_data <= fill_q;
            end
            if (abort)
                state <= ST_IDLE;
            else case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        after_arm <= start;
                        fill_q    <= fill_color;
                        mode_q    <= mode_cont;
                    end else if (start) begin
                        state     <= ST_ARMED;
                        cap_start <= 1'b1;
                        seen      <= 1'b0;
                        mode_q    <= mode_cont;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        state     <= after_arm ? ST_ARMED : ST_IDLE;
                        cap_start <= after_arm;
                        seen      <= 1'b0;
                    end
                end
                // a falling VSYNC only counts after a rising one, so capture starts on a frame boundary
                ST_ARMED: begin
                    if (rise)
                        seen <= 1'b1;
                    else if (fall && seen)
                        state <= ST_CAPTURE;
                end
                default: begin
                    if (rise) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        cap_start  <= mode_q;
                        if (!mode_q)
                            state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_capture_ctrl.sv
// tb_fb_capture_ctrl: vector table, directed corner sequences and randomized sessions
// checked against a write-stream scoreboard.
module tb_fb_capture_ctrl;
    import fb_pkg::*;
    logic clk = 0, rst = 0, start = 0, mode_cont = 0, clear_req = 0, abort = 0, vsync = 0, cap_we = 0;
    logic [7:0]  fill_color = 0, cap_data = 0;
    logic [16:0] cap_addr = 0;
    logic cap_start, fb_we, busy, clearing, frame_done, err;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data, frame_cnt;
    typedef struct {logic [16:0] a; logic [7:0] d;} wr_t;
    typedef struct {logic st, cr, ab, we; logic [16:0] ad; logic busy, clr, cs, err;} vec_t;
    wr_t wq[$], eq[$];
    vec_t tbl[8];
    int checks = 0, errors = 0, fd_cnt = 0, cs_cnt = 0;
    always #5 clk = ~clk;
    fb_capture_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode_cont(mode_cont), .clear_req(clear_req),
        .abort(abort), .fill_color(fill_color), .vsync(vsync), .cap_we(cap_we),
        .cap_addr(cap_addr), .cap_data(cap_data), .cap_start(cap_start), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .clearing(clearing),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .err(err)
    );
    always @(negedge clk) begin
        if (fb_we) wq.push_back('{fb_addr, fb_data});
        if (frame_done) fd_cnt++;
        if (cap_start) cs_cnt++;
    end
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic settle;
        @(negedge clk);
        #1;
    endtask
    task automatic idle_in;
        start = 0; mode_cont = 0; clear_req = 0; abort = 0; vsync = 0; cap_we = 0;
        cap_addr = 0; cap_data = 0; fill_color = 0;
    endtask
    task automatic do_reset;
        idle_in;
        @(negedge clk);
        rst = 0;
        #2;
        rst = 1;
    endtask
    task automatic enter_capture(input logic m);
        start = 1; mode_cont = m;
        tick;
        start = 0; vsync = 1;
        tick;
        vsync = 0;
        tick;
    endtask
    initial begin
        int fd0, cs0, n, nclr, ncap, bad, good, mism, exp_fc;
        logic exp_err, ab;
        tbl = '{'{0,0,0,0,17'd0,     0,0,0,0},
                '{1,0,0,0,17'd0,     1,0,1,0},
                '{0,1,0,0,17'd0,     1,1,0,0},
                '{1,1,0,0,17'd0,     1,1,0,0},
                '{1,0,1,0,17'd0,     0,0,0,0},
                '{0,1,1,0,17'd0,     0,0,0,0},
                '{0,0,0,1,17'd5,     0,0,0,1},
                '{0,0,0,1,17'd76800, 0,0,0,1}};
        do_reset;
        chk("reset_outs", {cap_start, fb_we, fb_addr, fb_data, busy, clearing, frame_done, frame_cnt, err}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            do_reset;
            tick;
            start = tbl[i].st; clear_req = tbl[i].cr; abort = tbl[i].ab; cap_we = tbl[i].we;
            cap_addr = tbl[i].ad; cap_data = 8'h5A;
            tick;
            idle_in;
            chk($sformatf("tbl%0d", i), {busy, clearing, cap_start, err, fb_we},
                {tbl[i].busy, tbl[i].clr, tbl[i].cs, tbl[i].err, 1'b0});
        end
        // single capture
        do_reset; wq.delete(); fd0 = fd_cnt; cs0 = cs_cnt;
        enter_capture(0);
        for (int i = 0; i < 10; i++) begin
            cap_we = 1; cap_addr = 17'(i); cap_data = 8'(8'h40 + i);
            tick;
            chk("single_wr", {fb_we, fb_addr, fb_data}, {1'b1, 17'(i), 8'(8'h40 + i)});
        end
        cap_we = 0; vsync = 1;
        tick;
        chk("single_end", {frame_done, frame_cnt, busy}, {1'b1, 8'd1, 1'b0});
        vsync = 0;
        tick; settle;
        chk("single_nwr", wq.size(), 10);
        chk("single_cs", cs_cnt - cs0, 1);
        chk("single_fd", fd_cnt - fd0, 1);
        // a falling VSYNC without a preceding rise must not open capture
        do_reset; vsync = 1; tick;
        start = 1; tick;
        start = 0; vsync = 0; tick;
        cap_we = 1; cap_addr = 3; tick;
        cap_we = 0;
        chk("midframe", {busy, fb_we, err}, 3'b101);
        abort = 1; tick; abort = 0;
        // error paths
        do_reset; enter_capture(0);
        cap_we = 1; cap_addr = 17'd76800; tick;
        cap_we = 0;
        chk("oor_cap", {fb_we, err}, 2'b01);
        vsync = 1; tick; vsync = 0; tick;
        cap_we = 1; cap_addr = 7; tick;
        cap_we = 0;
        chk("idle_we", {busy, fb_we, err}, 3'b001);
        tick; tick;
        chk("err_sticky", err, 1);
        start = 1; tick; start = 0;
        chk("err_clr_start", err, 0);
        abort = 1; tick; abort = 0;
        // clear with contention
        do_reset; tick; wq.delete();
        clear_req = 1; fill_color = 8'hE0; tick;
        clear_req = 0; fill_color = 8'h00;
        n = 0;
        while (clearing && n < 80000) begin
            cap_we = (n == 100 || n == 200 || n == 300); cap_addr = 5; cap_data = 8'h1F;
            tick;
            n++;
        end
        cap_we = 0;
        settle;
        nclr = 0; ncap = 0; bad = 0;
        foreach (wq[i]) begin
            if (wq[i].d == 8'hE0) begin
                if (wq[i].a != 17'(nclr)) bad++;
                nclr++;
            end else if (wq[i].d == 8'h1F && wq[i].a == 17'd5) ncap++;
            else bad++;
        end
        chk("clr_cycles", n, 76803);
        chk("clr_writes", nclr, 76800);
        chk("clr_cap", ncap, 3);
        chk("clr_order", bad, 0);
        chk("clr_end", {clearing, busy}, 2'b00);
        // abort a clear at address 1000
        do_reset; tick; wq.delete();
        clear_req = 1; fill_color = 8'h33; tick;
        clear_req = 0;
        repeat (1000) tick;
        abort = 1; tick; abort = 0;
        chk("abort_clr", {busy, clearing}, 2'b00);
        repeat (3) tick;
        settle;
        chk("abort_nwr", wq.size(), 1000);
        chk("abort_last", wq[wq.size()-1].a, 999);
        clear_req = 1; tick; clear_req = 0; tick;
        chk("clr_restart", {fb_we, fb_addr}, {1'b1, 17'd0});
        abort = 1; tick; abort = 0;
        // abort coincident with vsync rise in capture
        do_reset; enter_capture(0); fd0 = fd_cnt;
        vsync = 1; abort = 1; tick;
        abort = 0; vsync = 0;
        chk("abort_vs", {busy, frame_done}, 2'b00);
        tick; tick; settle;
        chk("abort_vs_fd", fd_cnt - fd0, 0);
        chk("abort_vs_cnt", frame_cnt, 0);
        // continuous mode with counter wrap
        do_reset; fd0 = fd_cnt; cs0 = cs_cnt; good = 0;
        enter_capture(1);
        for (int f = 0; f < 257; f++) begin
            vsync = 1; tick;
            if (frame_done && cap_start && busy) good++;
            vsync = 0; tick;
        end
        settle;
        chk("cont_pairs", good, 257);
        chk("cont_fd", fd_cnt - fd0, 257);
        chk("cont_cs", cs_cnt - cs0, 258);
        chk("cont_cnt", {frame_cnt, busy, clearing}, {8'd1, 1'b1, 1'b0});
        cap_we = 1; cap_addr = 9; cap_data = 8'hA5; tick;
        cap_we = 0;
        chk("cont_still_cap", {fb_we, fb_addr}, {1'b1, 17'd9});
        // async reset between edges
        @(posedge clk); #3;
        rst = 0; #1;
        chk("async_rst", {cap_start, fb_we, fb_addr, fb_data, busy, clearing, frame_done, frame_cnt, err}, 64'd0);
        rst = 1;
        tick;
        chk("after_rst", busy, 0);
        // randomized single-frame sessions against a write scoreboard
        do_reset; tick; exp_fc = 0; mism = 0;
        for (int s = 0; s < 25; s++) begin
            eq.delete(); wq.delete(); exp_err = 0;
            start = 1; tick; start = 0;
            repeat ($urandom_range(0, 3)) tick;
            vsync = 1;
            repeat ($urandom_range(1, 3)) tick;
            vsync = 0; tick;
            for (int i = 0; i < int'($urandom_range(5, 30)); i++) begin
                int a;
                a = ($urandom % 10 == 0) ? FB_SIZE + int'($urandom_range(0, 1000)) : int'($urandom_range(0, FB_SIZE - 1));
                cap_we = $urandom % 2; cap_addr = 17'(a); cap_data = 8'($urandom);
                if (cap_we) begin
                    if (a < FB_SIZE) eq.push_back('{17'(a), cap_data});
                    else exp_err = 1;
                end
                tick;
            end
            cap_we = 0;
            ab = ($urandom % 4 == 0);
            if (ab) abort = 1; else vsync = 1;
            tick;
            abort = 0; vsync = 0;
            if (!ab) exp_fc = (exp_fc + 1) % 256;
            tick; settle;
            if (wq.size() != eq.size()) mism++;
            else foreach (eq[i]) if (wq[i].a !== eq[i].a || wq[i].d !== eq[i].d) mism++;
            chk($sformatf("rnd%0d_st", s), {frame_cnt, err, busy}, {8'(exp_fc), exp_err, 1'b0});
        end
        chk("rnd_writes", mism, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
